// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO round-robin arbiter.
// Contents: FSM state enum, source-tag width helper, statistics counter width.
// Used by fifo_rr_arbiter_if, rr_pick and fifo_rr_arbiter via import fifo_arb_pkg::*.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Width of each per-requester beat counter (optional statistics)
  localparam int unsigned STATS_W = 32'd16;

  // Source-tag width for n requesters; n is at least 2 in any legal configuration
  function automatic int unsigned id_w(input int unsigned n);
    if (n < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: bundles the producer handshake, FIFO push port and status
// signals of the arbiter.
//   req/req_data/req_ack        : producer side (request, packed payloads, ack pulse)
//   fifo_push/fifo_wr_data/full : FIFO push side, wr_data = {owner_id, payload}
//   busy/grant_id               : grant status
//   beat_count/stats_clr        : only present when FIFO_ARB_STATS_EN is defined
// Modports: master = the arbiter, slave = producers + FIFO (the environment).
interface fifo_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 32'd4,
  parameter int unsigned WIDTH   = 32'd16
);
  import fifo_arb_pkg::*;

  localparam int unsigned ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ack;
  logic                     fifo_push;
  logic [ID_W+WIDTH-1:0]    fifo_wr_data;
  logic                     fifo_full;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic                         stats_clr;
  logic [NUM_REQ*STATS_W-1:0]   beat_count;

  modport master (
    input  req, req_data, fifo_full, stats_clr,
    output req_ack, fifo_push, fifo_wr_data, busy, grant_id, beat_count
  );
  modport slave (
    output req, req_data, fifo_full, stats_clr,
    input  req_ack, fifo_push, fifo_wr_data, busy, grant_id, beat_count
  );
`else
  modport master (
    input  req, req_data, fifo_full,
    output req_ack, fifo_push, fifo_wr_data, busy, grant_id
  );
  modport slave (
    output req, req_data, fifo_full,
    input  req_ack, fifo_push, fifo_wr_data, busy, grant_id
  );
`endif

endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
//   req_i        : request vector
//   last_grant_i : index of the previous owner; priority starts just after it
//   winner_o     : first requester found scanning last_grant+1, +2, ... mod NUM_REQ
//   any_req_o    : at least one request is present (winner_o only meaningful then)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 32'd4,
  parameter int unsigned ID_W    = 32'd2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_req_o
);

  logic [ID_W-1:0] idx_s;

  // Scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    winner_o = '0;
    idx_s    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_s    = ID_W'((32'(last_grant_i) + 32'(k)) % NUM_REQ);
      winner_o = req_i[idx_s] ? idx_s : winner_o;
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: shares one FIFO push port between NUM_REQ producers using
// round-robin arbitration with burst locking (up to BURST beats per grant).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : fifo_rr_arbiter_if.master (req/req_data/req_ack, fifo_push/
//         fifo_wr_data/fifo_full, busy/grant_id)
// Optional: defining FIFO_ARB_STATS_EN adds bus.beat_count (one saturating
// 16-bit accepted-beat counter per requester) and bus.stats_clr (sync clear).
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 32'd4,
  parameter int unsigned WIDTH   = 32'd16,
  parameter int unsigned BURST   = 32'd4
) (
  input logic               clk,
  input logic               rst,
  fifo_rr_arbiter_if.master bus
);

  localparam int unsigned ID_W  = id_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BURST + 32'd1);

  arb_state_e            state_q;
  logic [ID_W-1:0]       owner_q;
  logic [ID_W-1:0]       last_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ID_W+WIDTH-1:0] data_q;
  logic [ID_W+WIDTH-1:0] wdata_s;
  logic [ID_W-1:0]       winner_s;
  logic                  any_req_s;
  logic                  push_s;
  logic [NUM_REQ-1:0]    ack_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i        (bus.req),
    .last_grant_i (last_q),
    .winner_o     (winner_s),
    .any_req_o    (any_req_s)
  );

  // Push qualification and one-hot ack steering for the current owner
  always_comb begin
    push_s  = 1'b0;
    ack_s   = '0;
    wdata_s = {owner_q, bus.req_data[32'(owner_q) * WIDTH +: WIDTH]};
    if (state_q == LOCK) begin
      push_s = bus.req[owner_q] & ~bus.fifo_full;
    end else begin
      push_s = 1'b0;
    end
    if (push_s) begin
      ack_s[owner_q] = 1'b1;
    end else begin
      ack_s = '0;
    end
  end

  // Arbitration FSM: grant in IDLE, stream beats in LOCK until burst end or release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 32'd1);
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            owner_q <= winner_s;
            cnt_q   <= '0;
            state_q <= LOCK;
          end else begin
            state_q <= IDLE;
          end
        end
        LOCK: begin
          if (!bus.req[owner_q]) begin
            // owner ended its burst voluntarily
            state_q <= IDLE;
            last_q  <= owner_q;
          end else if (!bus.fifo_full) begin
            data_q <= wdata_s;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BURST - 32'd1)) begin
              state_q <= IDLE;
              last_q  <= owner_q;
            end else begin
              state_q <= LOCK;
            end
          end else begin
            // backpressure: hold everything, the grant is never stolen
            state_q <= LOCK;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_push    = push_s;
  assign bus.req_ack      = ack_s;
  // wr_data follows the live beat while pushing, otherwise holds the last pushed word
  assign bus.fifo_wr_data = push_s ? wdata_s : data_q;
  assign bus.busy         = (state_q == LOCK);
  assign bus.grant_id     = owner_q;

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][STATS_W-1:0] stat_q;

  // Per-requester saturating accepted-beat counters with synchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else if (bus.stats_clr) begin
      stat_q <= '0;
    end else if (push_s && (stat_q[owner_q] != {STATS_W{1'b1}})) begin
      stat_q[owner_q] <= stat_q[owner_q] + STATS_W'(1);
    end else begin
      stat_q <= stat_q;
    end
  end

  assign bus.beat_count = stat_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: self-checking bench for fifo_rr_arbiter (NUM_REQ=4,
// WIDTH=16, BURST=4). Producers are modelled as payload queues; a cycle-level
// reference model derived from the arbitration rules predicts every output.
module tb_fifo_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int BURST   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  fifo_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  fifo_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // producer payload queues and voluntary request drops
  logic [15:0] pq [NUM_REQ][$];
  logic [3:0]  hold_off;
  int          seen[$];

  // reference model state
  bit          m_locked;
  int          m_owner;
  int          m_beats;
  int          m_last;
  logic [17:0] m_data;

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i] = (pq[i].size() > 0) && !hold_off[i];
      bus.req_data[i*WIDTH +: WIDTH] = (pq[i].size() > 0) ? pq[i][0] : 16'h0000;
    end
  endtask

  // Expected {push, ack[3:0], wr_data[17:0], busy, grant_id-if-busy}
  function automatic logic [25:0] model_expect();
    logic        p;
    logic [3:0]  a;
    logic [17:0] d;
    p = m_locked && bus.req[m_owner] && !bus.fifo_full;
    a = p ? (4'b0001 << m_owner) : 4'b0000;
    d = p ? {2'(m_owner), bus.req_data[m_owner*WIDTH +: WIDTH]} : m_data;
    return {p, a, d, m_locked, m_locked ? 2'(m_owner) : 2'b00};
  endfunction

  function automatic logic [25:0] observe();
    return {bus.fifo_push, bus.req_ack, bus.fifo_wr_data, bus.busy,
            bus.busy ? bus.grant_id : 2'b00};
  endfunction

  // Advance the model across one clock edge and consume acked beats
  task automatic model_advance(input logic [3:0] ack);
    logic [3:0] r;
    r = bus.req;
    if (!m_locked) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (r[(m_last + k) % NUM_REQ]) begin
            m_owner = (m_last + k) % NUM_REQ;
            break;
          end
        end
        m_beats  = 0;
        m_locked = 1'b1;
      end
    end else if (!r[m_owner]) begin
      m_locked = 1'b0;
      m_last   = m_owner;
    end else if (!bus.fifo_full) begin
      m_data  = {2'(m_owner), bus.req_data[m_owner*WIDTH +: WIDTH]};
      m_beats = m_beats + 1;
      if (m_beats == BURST) begin
        m_locked = 1'b0;
        m_last   = m_owner;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) void'(pq[i].pop_front());
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
    m_last   = NUM_REQ - 1;
    m_data   = 18'h0;
  endtask

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) pq[i].push_back(16'($urandom));
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.fifo_full = 1'b0;
    hold_off      = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    seen.delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [25:0] ov;
    do_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) load(i, 3);
    drive_inputs();
    #2;
    ov = observe();
    checks++;
    if ({ov, bus.grant_id} !== 28'h0) begin
      fails++;
      $display("FAIL reset_outputs got=%h required=0", {ov, bus.grant_id});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.fifo_push !== 1'b0) begin
      fails++;
      $display("FAIL reset_arb_cycle busy=%b push=%b required 0 0", bus.busy, bus.fifo_push);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.grant_id, bus.fifo_push} !== {1'b1, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_first_grant busy=%b id=%0d push=%b required 1 0 1",
               bus.busy, bus.grant_id, bus.fifo_push);
    end
  endtask

  task automatic test_single();
    logic [25:0] ev, ov;
    logic [9:0]  pmask;
    do_reset();
    pmask = '0;
    load(2, 6);
    drive_inputs();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ev = model_expect();
      ov = observe();
      checks++;
      if (ov !== ev) begin
        fails++;
        $display("FAIL single c=%0d got=%h required=%h", c, ov, ev);
      end
      if (bus.fifo_push) begin
        seen.push_back(int'(bus.fifo_wr_data[17:16]));
        pmask[c] = 1'b1;
      end
      @(posedge clk);
      model_advance(ev[24:21]);
      #1;
      drive_inputs();
    end
    checks++;
    if (pmask !== 10'b0011011110 || seen.size() != 6 || seen[0] != 2 || seen[5] != 2) begin
      fails++;
      $display("FAIL single_timing pushmask=%b n=%0d required mask=0011011110 n=6 id=2",
               pmask, seen.size());
    end
  endtask

  task automatic test_all_four();
    logic [25:0] ev, ov;
    int bad;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) load(i, 12);
    drive_inputs();
    for (int c = 0; c < 62; c++) begin
      @(negedge clk);
      ev = model_expect();
      ov = observe();
      checks++;
      if (ov !== ev || !$onehot0(bus.req_ack)) begin
        fails++;
        $display("FAIL all_four c=%0d got=%h required=%h", c, ov, ev);
      end
      if (bus.fifo_push) seen.push_back(int'(bus.fifo_wr_data[17:16]));
      @(posedge clk);
      model_advance(ev[24:21]);
      #1;
      drive_inputs();
    end
    bad = 0;
    for (int k = 0; k < seen.size(); k++) if (seen[k] != (k / BURST) % NUM_REQ) bad++;
    checks++;
    if (seen.size() != 48 || bad != 0) begin
      fails++;
      $display("FAIL all_four_order beats=%0d misordered=%0d required 48 0", seen.size(), bad);
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] ev, ov;
    logic [9:0]  pmask;
    do_reset();
    pmask = '0;
    load(1, 4);
    drive_inputs();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ev = model_expect();
      ov = observe();
      checks++;
      if (ov !== ev) begin
        fails++;
        $display("FAIL backpressure c=%0d got=%h required=%h", c, ov, ev);
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if ({bus.fifo_push, bus.req_ack, bus.busy, bus.grant_id} !== {1'b0, 4'b0000, 1'b1, 2'd1}) begin
          fails++;
          $display("FAIL stall_hold c=%0d push=%b ack=%b busy=%b id=%0d required 0 0000 1 1",
                   c, bus.fifo_push, bus.req_ack, bus.busy, bus.grant_id);
        end
      end
      if (bus.fifo_push) pmask[c] = 1'b1;
      @(posedge clk);
      model_advance(ev[24:21]);
      #1;
      bus.fifo_full = (c + 1 >= 3) && (c + 1 <= 5);
      drive_inputs();
    end
    checks++;
    if (pmask !== 10'b0011000110) begin
      fails++;
      $display("FAIL backpressure_beats pushmask=%b required=0011000110", pmask);
    end
  endtask

  task automatic test_early_release();
    logic [25:0] ev, ov;
    do_reset();
    load(3, 2);
    drive_inputs();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ev = model_expect();
      ov = observe();
      checks++;
      if (ov !== ev) begin
        fails++;
        $display("FAIL early_release c=%0d got=%h required=%h", c, ov, ev);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (bus.busy !== (c == 3) || bus.fifo_push !== 1'b0) begin
          fails++;
          $display("FAIL release_cycle c=%0d busy=%b push=%b", c, bus.busy, bus.fifo_push);
        end
      end
      if (bus.fifo_push) seen.push_back(int'(bus.fifo_wr_data[17:16]));
      @(posedge clk);
      model_advance(ev[24:21]);
      #1;
      if (c == 0) begin
        load(1, 2);
        load(0, 2);
      end
      drive_inputs();
    end
    checks++;
    if (seen.size() != 6 || seen[0] != 3 || seen[1] != 3 || seen[2] != 0 || seen[3] != 0 ||
        seen[4] != 1 || seen[5] != 1) begin
      fails++;
      $display("FAIL early_release_order n=%0d first_after_release=%0d required 6 beats ids 3,3,0,0,1,1",
               seen.size(), (seen.size() > 2) ? seen[2] : -1);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [25:0] ev, ov;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) load(i, 8);
    drive_inputs();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ev = model_expect();
      @(posedge clk);
      model_advance(ev[24:21]);
      #1;
      drive_inputs();
    end
    #2;
    rst = 1'b1;
    #1;
    ov = observe();
    checks++;
    if ({ov, bus.grant_id} !== 28'h0) begin
      fails++;
      $display("FAIL reset_mid_burst_async got=%h required=0", {ov, bus.grant_id});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive_inputs();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ev = model_expect();
      ov = observe();
      checks++;
      if (ov !== ev) begin
        fails++;
        $display("FAIL after_reset c=%0d got=%h required=%h", c, ov, ev);
      end
      if (bus.fifo_push) seen.push_back(int'(bus.fifo_wr_data[17:16]));
      @(posedge clk);
      model_advance(ev[24:21]);
      #1;
      drive_inputs();
    end
    checks++;
    if (seen.size() == 0 || seen[0] != 0) begin
      fails++;
      $display("FAIL after_reset_winner got=%0d required=0", (seen.size() > 0) ? seen[0] : -1);
    end
  endtask

  task automatic test_random();
    logic [25:0] ev, ov;
    int pushes;
    do_reset();
    pushes = 0;
    for (int i = 0; i < NUM_REQ; i++) load(i, $urandom_range(0, 6));
    drive_inputs();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ev = model_expect();
      ov = observe();
      checks++;
      if (ov !== ev || !$onehot0(bus.req_ack) || (bus.fifo_full && bus.req_ack != 4'b0000)) begin
        fails++;
        $display("FAIL random c=%0d got=%h required=%h full=%b", c, ov, ev, bus.fifo_full);
      end
      if (bus.fifo_push) pushes++;
      @(posedge clk);
      model_advance(ev[24:21]);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, NUM_REQ - 1);
        if (pq[r].size() < 8) load(r, $urandom_range(1, 5));
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_REQ; i++) hold_off[i] = ($urandom_range(0, 7) == 0);
      drive_inputs();
    end
    checks++;
    if (pushes < 50) begin
      fails++;
      $display("FAIL random_activity pushes=%0d required>=50", pushes);
    end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    int cnt;
    int cyc;
    do_reset();
    bus.req      = 4'b0001;
    bus.req_data = {4{16'h5a5a}};
    cnt = 0;
    cyc = 0;
    while (cnt < 70000 && cyc < 95000) begin
      @(negedge clk);
      if (cnt == 100) begin
        checks++;
        if (bus.beat_count[15:0] !== 16'd100) begin
          fails++;
          $display("FAIL stats_count got=%0d required=100", bus.beat_count[15:0]);
        end
      end
      if (bus.fifo_push) cnt++;
      cyc++;
    end
    @(posedge clk);
    #1;
    bus.req = 4'b0000;
    @(negedge clk);
    checks++;
    if (cnt != 70000 || bus.beat_count !== {48'h0, 16'hffff}) begin
      fails++;
      $display("FAIL stats_saturate beats=%0d counters=%h required 70000 and 0000_0000_0000_ffff",
               cnt, bus.beat_count);
    end
    bus.stats_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.stats_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.beat_count !== 64'h0) begin
      fails++;
      $display("FAIL stats_clear got=%h required=0", bus.beat_count);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req       = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    hold_off      = 4'b0000;
`ifdef FIFO_ARB_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_random();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
